// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter_if
// Brief    : Video, host, blitter, VRAM and perf-counter signals of vram_arbiter.
// Revision : 1.0
// ============================================================================
interface vram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              vid_blit_cycle_i;
    logic              vid_sel_i;
    logic [ADDR_W-1:0] vid_addr_i;

    logic              host_req_i;
    logic              host_wr_i;
    logic [ADDR_W-1:0] host_addr_i;
    logic [DATA_W-1:0] host_data_i;
    logic              host_ack_o;
    logic              host_rd_valid_o;
    logic [DATA_W-1:0] host_data_o;

    logic              blit_req_i;
    logic              blit_wr_i;
    logic [ADDR_W-1:0] blit_addr_i;
    logic [DATA_W-1:0] blit_data_i;
    logic              blit_ack_o;
    logic              blit_rd_valid_o;
    logic [DATA_W-1:0] blit_data_o;

    logic              vram_sel_o;
    logic              vram_wr_o;
    logic [ADDR_W-1:0] vram_addr_o;
    logic [DATA_W-1:0] vram_data_o;
    logic [DATA_W-1:0] vram_data_i;

    logic [15:0]       host_wait_cnt_o;
    logic [15:0]       blit_wait_cnt_o;
    logic              perf_clr_i;

    modport slave (
        input  vid_blit_cycle_i, vid_sel_i, vid_addr_i,
        input  host_req_i, host_wr_i, host_addr_i, host_data_i,
        output host_ack_o, host_rd_valid_o, host_data_o,
        input  blit_req_i, blit_wr_i, blit_addr_i, blit_data_i,
        output blit_ack_o, blit_rd_valid_o, blit_data_o,
        output vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o,
        input  vram_data_i,
        output host_wait_cnt_o, blit_wait_cnt_o,
        input  perf_clr_i
    );

    modport master (
        output vid_blit_cycle_i, vid_sel_i, vid_addr_i,
        output host_req_i, host_wr_i, host_addr_i, host_data_i,
        input  host_ack_o, host_rd_valid_o, host_data_o,
        output blit_req_i, blit_wr_i, blit_addr_i, blit_data_i,
        input  blit_ack_o, blit_rd_valid_o, blit_data_o,
        input  vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o,
        output vram_data_i,
        input  host_wait_cnt_o, blit_wait_cnt_o,
        output perf_clr_i
    );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Single-port VRAM sharing: video passthrough, round-robin host/blit.
//            Optional wait counters enabled by macro VRAM_ARB_PERF_EN.
// Revision : 1.0
// ============================================================================
module vram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  wire logic      clk,
    input  wire logic      reset_n_i,
    vram_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        GNT_HOST = 1'b0,
        GNT_BLIT = 1'b1
    } gnt_e;

    gnt_e              last_grant_q, last_grant_d;
    logic              host_ack, blit_ack;
    logic              host_rd_pend_q, host_rd_cap_q;
    logic              blit_rd_pend_q, blit_rd_cap_q;
    logic [DATA_W-1:0] host_data_q, blit_data_q;

    // Acks are gated by reset so nothing is issued while reset is held.
    always_comb begin
        host_ack = 1'b0;
        blit_ack = 1'b0;
        if (reset_n_i && bus.vid_blit_cycle_i) begin
            if (bus.host_req_i && (!bus.blit_req_i || last_grant_q == GNT_BLIT))
                host_ack = 1'b1;
            else if (bus.blit_req_i)
                blit_ack = 1'b1;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (host_ack)
            last_grant_d = GNT_HOST;
        else if (blit_ack)
            last_grant_d = GNT_BLIT;
    end

    always_comb begin
        bus.vram_sel_o  = 1'b0;
        bus.vram_wr_o   = 1'b0;
        bus.vram_addr_o = '0;
        bus.vram_data_o = '0;
        if (!bus.vid_blit_cycle_i) begin
            bus.vram_sel_o  = bus.vid_sel_i & reset_n_i;
            bus.vram_addr_o = bus.vid_addr_i;
        end else if (host_ack) begin
            bus.vram_sel_o  = 1'b1;
            bus.vram_wr_o   = bus.host_wr_i;
            bus.vram_addr_o = bus.host_addr_i;
            bus.vram_data_o = bus.host_data_i;
        end else if (blit_ack) begin
            bus.vram_sel_o  = 1'b1;
            bus.vram_wr_o   = bus.blit_wr_i;
            bus.vram_addr_o = bus.blit_addr_i;
            bus.vram_data_o = bus.blit_data_i;
        end
    end

    // Read return: ack -> pend (VRAM data arrives) -> cap (data and valid visible).
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_grant_q   <= GNT_BLIT;
            host_rd_pend_q <= 1'b0;
            host_rd_cap_q  <= 1'b0;
            host_data_q    <= '0;
            blit_rd_pend_q <= 1'b0;
            blit_rd_cap_q  <= 1'b0;
            blit_data_q    <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            host_rd_pend_q <= host_ack & ~bus.host_wr_i;
            host_rd_cap_q  <= host_rd_pend_q;
            blit_rd_pend_q <= blit_ack & ~bus.blit_wr_i;
            blit_rd_cap_q  <= blit_rd_pend_q;
            if (host_rd_pend_q)
                host_data_q <= bus.vram_data_i;
            if (blit_rd_pend_q)
                blit_data_q <= bus.vram_data_i;
        end
    end

    assign bus.host_ack_o      = host_ack;
    assign bus.blit_ack_o      = blit_ack;
    assign bus.host_rd_valid_o = host_rd_cap_q;
    assign bus.blit_rd_valid_o = blit_rd_cap_q;
    assign bus.host_data_o     = host_data_q;
    assign bus.blit_data_o     = blit_data_q;

`ifdef VRAM_ARB_PERF_EN
    logic [15:0] host_wait_q, blit_wait_q;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            host_wait_q <= 16'h0000;
            blit_wait_q <= 16'h0000;
        end else if (bus.perf_clr_i) begin
            host_wait_q <= 16'h0000;
            blit_wait_q <= 16'h0000;
        end else begin
            if (bus.host_req_i && !host_ack && host_wait_q != 16'hFFFF)
                host_wait_q <= host_wait_q + 16'd1;
            if (bus.blit_req_i && !blit_ack && blit_wait_q != 16'hFFFF)
                blit_wait_q <= blit_wait_q + 16'd1;
        end
    end

    assign bus.host_wait_cnt_o = host_wait_q;
    assign bus.blit_wait_cnt_o = blit_wait_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr     = bus.perf_clr_i;
    assign bus.host_wait_cnt_o = 16'h0000;
    assign bus.blit_wait_cnt_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Directed scenarios plus randomized traffic checked against a
//            grant/read-return reference model.
// Revision : 1.0
// ============================================================================
module tb_vram_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // VRAM behavioural model: 256 words aliased on the low address byte.
    logic [15:0] mem [0:255];
    logic        mem_init = 1'b0;

    function automatic logic [15:0] init_word(int i);
        return 16'(i * 40503) ^ 16'hA5C3;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (bus.vram_sel_o && bus.vram_wr_o) begin
            mem[bus.vram_addr_o[7:0]] <= bus.vram_data_o;
        end
        bus.vram_data_i <= mem[bus.vram_addr_o[7:0]];
    end

    task automatic idle_inputs();
        bus.vid_blit_cycle_i = 1'b0; bus.vid_sel_i = 1'b0; bus.vid_addr_i = '0;
        bus.host_req_i = 1'b0; bus.host_wr_i = 1'b0; bus.host_addr_i = '0; bus.host_data_i = '0;
        bus.blit_req_i = 1'b0; bus.blit_wr_i = 1'b0; bus.blit_addr_i = '0; bus.blit_data_i = '0;
        bus.perf_clr_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 reset_n = 1'b0;
        bus.vid_blit_cycle_i = 1'b0; bus.vid_sel_i = 1'b1;
        bus.host_req_i = 1'b1; bus.blit_req_i = 1'b1; bus.blit_wr_i = 1'b1;
        next_cycle();
        #2;
        n_total++;
        if ({bus.vram_sel_o, bus.vram_wr_o, bus.host_ack_o, bus.blit_ack_o,
             bus.host_rd_valid_o, bus.blit_rd_valid_o} !== 6'b0)
            $display("FAIL reset_ctrl: got sel/wr/acks/valids=%b want 000000",
                     {bus.vram_sel_o, bus.vram_wr_o, bus.host_ack_o, bus.blit_ack_o,
                      bus.host_rd_valid_o, bus.blit_rd_valid_o});
        else n_pass++;
        bus.vid_blit_cycle_i = 1'b1;
        #1;
        n_total++;
        if ({bus.vram_sel_o, bus.host_ack_o, bus.blit_ack_o, bus.host_data_o, bus.blit_data_o} !== 35'h0)
            $display("FAIL reset_blit_cycle: got sel=%b acks=%b%b hdata=%h bdata=%h want all 0",
                     bus.vram_sel_o, bus.host_ack_o, bus.blit_ack_o, bus.host_data_o, bus.blit_data_o);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_video_passthrough();
        do_reset();
        bus.vid_blit_cycle_i = 1'b0; bus.vid_sel_i = 1'b1; bus.vid_addr_i = 16'h1234;
        bus.host_req_i = 1'b1; bus.host_wr_i = 1'b1; bus.host_addr_i = 16'h0055; bus.host_data_i = 16'h7777;
        #2;
        n_total++;
        if ({bus.vram_sel_o, bus.vram_wr_o, bus.vram_addr_o, bus.vram_data_o, bus.host_ack_o}
            !== {1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0})
            $display("FAIL video_pass: got sel=%b wr=%b addr=%h data=%h ack=%b want 1 0 1234 0000 0",
                     bus.vram_sel_o, bus.vram_wr_o, bus.vram_addr_o, bus.vram_data_o, bus.host_ack_o);
        else n_pass++;
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_host_read();
        do_reset();
        bus.vid_blit_cycle_i = 1'b1;
        bus.host_req_i = 1'b1; bus.host_wr_i = 1'b1; bus.host_addr_i = 16'h0042; bus.host_data_i = 16'hBEEF;
        #2;
        n_total++;
        if ({bus.host_ack_o, bus.vram_sel_o, bus.vram_wr_o, bus.vram_addr_o, bus.vram_data_o}
            !== {1'b1, 1'b1, 1'b1, 16'h0042, 16'hBEEF})
            $display("FAIL host_write_setup: got ack=%b sel=%b wr=%b addr=%h data=%h want 1 1 1 0042 beef",
                     bus.host_ack_o, bus.vram_sel_o, bus.vram_wr_o, bus.vram_addr_o, bus.vram_data_o);
        else n_pass++;
        next_cycle();
        bus.host_wr_i = 1'b0; bus.host_data_i = 16'h0000;
        #2;
        n_total++;
        if ({bus.host_ack_o, bus.vram_sel_o, bus.vram_wr_o, bus.vram_addr_o} !== {3'b110, 16'h0042})
            $display("FAIL host_read_ack: got ack=%b sel=%b wr=%b addr=%h want 1 1 0 0042",
                     bus.host_ack_o, bus.vram_sel_o, bus.vram_wr_o, bus.vram_addr_o);
        else n_pass++;
        next_cycle();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            #2;
            n_total++;
            if (k == 1 && bus.host_rd_valid_o !== 1'b0)
                $display("FAIL host_read_n1: got valid=%b want 0", bus.host_rd_valid_o);
            else if (k == 2 && {bus.host_rd_valid_o, bus.host_data_o} !== {1'b1, 16'hBEEF})
                $display("FAIL host_read_n2: got valid=%b data=%h want 1 beef",
                         bus.host_rd_valid_o, bus.host_data_o);
            else if (k == 3 && {bus.host_rd_valid_o, bus.host_data_o} !== {1'b0, 16'hBEEF})
                $display("FAIL host_read_n3: got valid=%b data=%h want 0 beef",
                         bus.host_rd_valid_o, bus.host_data_o);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_blit_write();
        do_reset();
        bus.vid_blit_cycle_i = 1'b1;
        bus.blit_req_i = 1'b1; bus.blit_wr_i = 1'b1; bus.blit_addr_i = 16'h8000; bus.blit_data_i = 16'h5A5A;
        #2;
        n_total++;
        if ({bus.blit_ack_o, bus.host_ack_o, bus.vram_sel_o, bus.vram_wr_o, bus.vram_addr_o, bus.vram_data_o}
            !== {4'b1011, 16'h8000, 16'h5A5A})
            $display("FAIL blit_write: got back=%b hack=%b sel=%b wr=%b addr=%h data=%h want 1 0 1 1 8000 5a5a",
                     bus.blit_ack_o, bus.host_ack_o, bus.vram_sel_o, bus.vram_wr_o,
                     bus.vram_addr_o, bus.vram_data_o);
        else n_pass++;
        next_cycle();
        bus.blit_req_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            n_total++;
            if ({bus.blit_ack_o, bus.blit_rd_valid_o} !== 2'b00)
                $display("FAIL blit_write_after_%0d: got ack=%b valid=%b want 0 0",
                         k, bus.blit_ack_o, bus.blit_rd_valid_o);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_contention();
        bit host_next = 1'b1;
        do_reset();
        bus.host_req_i = 1'b1; bus.host_wr_i = 1'b1; bus.host_addr_i = 16'h0001; bus.host_data_i = 16'h1111;
        bus.blit_req_i = 1'b1; bus.blit_wr_i = 1'b1; bus.blit_addr_i = 16'h0002; bus.blit_data_i = 16'h2222;
        for (int i = 0; i < 16; i++) begin
            logic [1:0] exp_ack;
            bus.vid_blit_cycle_i = ((i % 4) >= 2);
            #2;
            exp_ack = 2'b00;
            if (bus.vid_blit_cycle_i) begin
                exp_ack   = host_next ? 2'b10 : 2'b01;
                host_next = !host_next;
            end
            n_total++;
            if ({bus.host_ack_o, bus.blit_ack_o} !== exp_ack)
                $display("FAIL contention_%0d: got host/blit ack=%b want %b",
                         i, {bus.host_ack_o, bus.blit_ack_o}, exp_ack);
            else n_pass++;
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        bus.vid_blit_cycle_i = 1'b1;
        bus.host_req_i = 1'b1; bus.host_wr_i = 1'b0; bus.host_addr_i = 16'h0042;
        #2;
        n_total++;
        if (bus.host_ack_o !== 1'b1)
            $display("FAIL midreset_ack: got %b want 1", bus.host_ack_o);
        else n_pass++;
        next_cycle();
        idle_inputs();
        bus.vid_sel_i = 1'b1;
        reset_n = 1'b0;
        #2;
        n_total++;
        if ({bus.vram_sel_o, bus.host_rd_valid_o, bus.host_data_o} !== 18'h0)
            $display("FAIL midreset_during: got sel=%b valid=%b data=%h want 0 0 0000",
                     bus.vram_sel_o, bus.host_rd_valid_o, bus.host_data_o);
        else n_pass++;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        bus.vid_sel_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            n_total++;
            if ({bus.host_rd_valid_o, bus.host_data_o} !== 17'h0)
                $display("FAIL midreset_after_%0d: got valid=%b data=%h want 0 0000",
                         k, bus.host_rd_valid_o, bus.host_data_o);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_perf();
        logic [15:0] exp_wait;
`ifdef VRAM_ARB_PERF_EN
        exp_wait = 16'd3;
`else
        exp_wait = 16'd0;
`endif
        do_reset();
        bus.host_req_i = 1'b1; bus.host_wr_i = 1'b1; bus.host_addr_i = 16'h0005;
        for (int k = 0; k < 4; k++) begin
            bus.vid_blit_cycle_i = (k == 3);
            next_cycle();
        end
        idle_inputs();
        #2;
        n_total++;
        if ({bus.host_wait_cnt_o, bus.blit_wait_cnt_o} !== {exp_wait, 16'd0})
            $display("FAIL perf_count: got host=%0d blit=%0d want %0d 0",
                     bus.host_wait_cnt_o, bus.blit_wait_cnt_o, exp_wait);
        else n_pass++;
        bus.perf_clr_i = 1'b1;
        next_cycle();
        bus.perf_clr_i = 1'b0;
        #2;
        n_total++;
        if (bus.host_wait_cnt_o !== 16'd0)
            $display("FAIL perf_clear: got %0d want 0", bus.host_wait_cnt_o);
        else n_pass++;
        next_cycle();
    endtask

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_t;

    task automatic test_random();
        rd_t         hq[$], bq[$];
        logic [15:0] ref_mem [0:255];
        logic [15:0] h_hold = 16'h0, b_hold = 16'h0;
        logic [15:0] h_cnt = 16'h0, b_cnt = 16'h0;
        bit          last_host = 1'b0;
        bit          h_acked = 1'b0, b_acked = 1'b0;
        int          errs = 0;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        mem_init = 1'b1;
        do_reset();
        mem_init = 1'b0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            int          gnt;
            logic [15:0] e_addr, e_data;
            logic        e_sel, e_wr, e_hv, e_bv;
            logic [15:0] e_hd, e_bd;

            if (!bus.host_req_i || h_acked) begin
                bus.host_req_i  = ($urandom_range(0, 1) == 1);
                bus.host_wr_i   = ($urandom_range(0, 2) == 0);
                bus.host_addr_i = 16'($urandom_range(0, 255));
                bus.host_data_i = 16'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                bus.host_req_i = 1'b0;
            end
            if (!bus.blit_req_i || b_acked) begin
                bus.blit_req_i  = ($urandom_range(0, 1) == 1);
                bus.blit_wr_i   = ($urandom_range(0, 1) == 0);
                bus.blit_addr_i = 16'($urandom_range(0, 255));
                bus.blit_data_i = 16'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                bus.blit_req_i = 1'b0;
            end
            bus.vid_blit_cycle_i = ($urandom_range(0, 1) == 1);
            bus.vid_sel_i        = ($urandom_range(0, 1) == 1);
            bus.vid_addr_i       = 16'($urandom);
            bus.perf_clr_i       = ($urandom_range(0, 31) == 0);
            #2;

            // 0 = none, 1 = host, 2 = blit
            gnt = 0;
            if (bus.vid_blit_cycle_i) begin
                if (bus.host_req_i && bus.blit_req_i) gnt = last_host ? 2 : 1;
                else if (bus.host_req_i)               gnt = 1;
                else if (bus.blit_req_i)               gnt = 2;
            end

            e_sel = 1'b0; e_wr = 1'b0; e_addr = 16'h0; e_data = 16'h0;
            if (!bus.vid_blit_cycle_i) begin
                e_sel = bus.vid_sel_i; e_addr = bus.vid_addr_i;
            end else if (gnt == 1) begin
                e_sel = 1'b1; e_wr = bus.host_wr_i; e_addr = bus.host_addr_i; e_data = bus.host_data_i;
            end else if (gnt == 2) begin
                e_sel = 1'b1; e_wr = bus.blit_wr_i; e_addr = bus.blit_addr_i; e_data = bus.blit_data_i;
            end

            n_total++;
            if ({bus.host_ack_o, bus.blit_ack_o, bus.vram_sel_o, bus.vram_wr_o} !== {gnt == 1, gnt == 2, e_sel, e_wr}
                || (e_sel && {bus.vram_addr_o, bus.vram_data_o} !== {e_addr, e_data})) begin
                if (errs < 10)
                    $display("FAIL rand_bus cyc%0d: got ack=%b%b sel=%b wr=%b addr=%h data=%h want %b%b %b %b %h %h",
                             cyc, bus.host_ack_o, bus.blit_ack_o, bus.vram_sel_o, bus.vram_wr_o,
                             bus.vram_addr_o, bus.vram_data_o, gnt == 1, gnt == 2, e_sel, e_wr, e_addr, e_data);
                errs++;
            end else n_pass++;

            e_hv = (hq.size() > 0 && hq[0].due == cyc);
            e_bv = (bq.size() > 0 && bq[0].due == cyc);
            if (e_hv) begin h_hold = hq[0].data; void'(hq.pop_front()); end
            if (e_bv) begin b_hold = bq[0].data; void'(bq.pop_front()); end
            e_hd = h_hold; e_bd = b_hold;

            n_total++;
            if ({bus.host_rd_valid_o, bus.host_data_o, bus.blit_rd_valid_o, bus.blit_data_o}
                !== {e_hv, e_hd, e_bv, e_bd}) begin
                if (errs < 10)
                    $display("FAIL rand_read cyc%0d: got h=%b/%h b=%b/%h want h=%b/%h b=%b/%h",
                             cyc, bus.host_rd_valid_o, bus.host_data_o, bus.blit_rd_valid_o,
                             bus.blit_data_o, e_hv, e_hd, e_bv, e_bd);
                errs++;
            end else n_pass++;

            n_total++;
            if ({bus.host_wait_cnt_o, bus.blit_wait_cnt_o} !== {h_cnt, b_cnt}) begin
                if (errs < 10)
                    $display("FAIL rand_perf cyc%0d: got %0d/%0d want %0d/%0d",
                             cyc, bus.host_wait_cnt_o, bus.blit_wait_cnt_o, h_cnt, b_cnt);
                errs++;
            end else n_pass++;

            if (gnt == 1) begin
                last_host = 1'b1;
                if (bus.host_wr_i) ref_mem[bus.host_addr_i[7:0]] = bus.host_data_i;
                else hq.push_back('{due: cyc + 2, data: ref_mem[bus.host_addr_i[7:0]]});
            end else if (gnt == 2) begin
                last_host = 1'b0;
                if (bus.blit_wr_i) ref_mem[bus.blit_addr_i[7:0]] = bus.blit_data_i;
                else bq.push_back('{due: cyc + 2, data: ref_mem[bus.blit_addr_i[7:0]]});
            end
`ifdef VRAM_ARB_PERF_EN
            if (bus.perf_clr_i) begin
                h_cnt = 16'h0; b_cnt = 16'h0;
            end else begin
                if (bus.host_req_i && gnt != 1 && h_cnt != 16'hFFFF) h_cnt = h_cnt + 16'd1;
                if (bus.blit_req_i && gnt != 2 && b_cnt != 16'hFFFF) b_cnt = b_cnt + 16'd1;
            end
`endif
            h_acked = (gnt == 1);
            b_acked = (gnt == 2);
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_video_passthrough();
        test_host_read();
        test_blit_write();
        test_contention();
        test_reset_mid_read();
        test_perf();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port VRAM between the video generator, the host register interface and the blitter.
- Video always owns cycles where the video generator's blit_cycle signal is 0 and passes through with zero added latency.
- Blit cycles (blit_cycle=1) go to host or blitter by round-robin, using a req/ack handshake.
- Each requester gets a registered read-data return with fixed latency.

Parameters:
- ADDR_W, 16, VRAM word address width
- DATA_W, 16, VRAM word width

Ports:
- clk  in  1  pixel/system clock
- reset_n_i  in  1  reset; one clock; asynchronous assert, active-low
- vid_blit_cycle_i  in  1  0 = video owns VRAM this cycle, 1 = arbitrated cycle
- vid_sel_i  in  1  video VRAM select
- vid_addr_i  in  ADDR_W  video VRAM address
- host_req_i  in  1  host access request; held until ack
- host_wr_i  in  1  1 = write, 0 = read
- host_addr_i  in  ADDR_W  host address
- host_data_i  in  DATA_W  host write data
- host_ack_o  out  1  access issued this cycle (combinational)
- host_rd_valid_o  out  1  one-cycle pulse: host_data_o holds new read data
- host_data_o  out  DATA_W  host read data, held until next host read returns
- blit_req_i, blit_wr_i, blit_addr_i, blit_data_i  in  1/1/ADDR_W/DATA_W  blitter request, same rules as host
- blit_ack_o, blit_rd_valid_o, blit_data_o  out  1/1/DATA_W  blitter response, same rules as host
- vram_sel_o  out  1  VRAM select
- vram_wr_o  out  1  VRAM write enable
- vram_addr_o  out  ADDR_W  VRAM address
- vram_data_o  out  DATA_W  VRAM write data
- vram_data_i  in  DATA_W  VRAM read data, valid one cycle after sel
- host_wait_cnt_o, blit_wait_cnt_o  out  16 each  performance counters (see Optional Feature)
- perf_clr_i  in  1  synchronous clear of performance counters

Behaviour:
- Reset (reset_n_i low, async):
  - last_grant = BLIT, so host wins the first tie.
  - All acks and rd_valids 0; host_data_o and blit_data_o 0; read pipelines cleared.
  - vram_sel_o and vram_wr_o forced 0 while in reset.
- Video cycle (vid_blit_cycle_i=0):
  - vram_sel_o = vid_sel_i, vram_addr_o = vid_addr_i, vram_wr_o = 0, vram_data_o = 0.
  - No ack issued; pending requests wait.
- Arbitrated cycle (vid_blit_cycle_i=1); vid_sel_i is ignored:
  - Only one requester: that requester is granted.
  - Both requesting: grant the one not equal to last_grant.
  - Neither requesting: vram_sel_o = 0, last_grant unchanged.
  - Grant drives vram_sel_o = 1, vram_wr_o = req_wr, plus addr/data from the granted requester.
  - The granted ack_o is high that same cycle; last_grant updates at the clock edge.
- Handshake:
  - Requester keeps req/wr/addr/data stable until it samples ack=1 at a clock edge.
  - It may re-request on the very next cycle.
  - Dropping req before ack is legal: no access occurs, nothing is reported.
- Read return, per requester, via a 2-stage pipeline (rd_pend, rd_cap):
  - Cycle N: read ack.
  - Cycle N+1: vram_data_i captured into x_data_o at the end of the cycle.
  - Cycle N+2: x_rd_valid_o = 1 for exactly one cycle.
  - Back-to-back read acks yield back-to-back rd_valid pulses, each with its own data.
- Writes produce no rd_valid.
- Throughput: maximum one access per arbitrated cycle. With video/blit alternating every 2 cycles, each requester is guaranteed at least 1 of every 4 arbitrated cycles under contention.
- No starvation: a requester that is held off wins the next arbitrated cycle.
- Reset asserted mid-read: the read is dropped and no rd_valid is ever emitted for it.

Optional Feature:
- Macro: VRAM_ARB_PERF_EN.
- Defined:
  - host_wait_cnt_o / blit_wait_cnt_o increment each cycle that the corresponding req_i=1 and ack_o=0, including video cycles.
  - 16-bit, saturating at 16'hFFFF.
  - Cleared by reset or by perf_clr_i=1; clear has priority over increment.
- Not defined: both counters tied to 16'h0000, perf_clr_i ignored, no counter flops synthesized.

Test Plan:
- Video passthrough: blit_cycle=0, vid_sel=1, vid_addr=16'h1234, host_req=1 -> vram_sel_o=1, vram_addr_o=16'h1234, vram_wr_o=0, host_ack_o=0.
- Host read: host_req=1, host_wr=0, addr=16'h0042 on a blit cycle, VRAM returns 16'hBEEF next cycle -> ack at N, host_rd_valid_o=1 at N+2 only, host_data_o=16'hBEEF held afterwards.
- Contention: both requesting continuously from reset, blit_cycle pattern 0,0,1,1 repeating -> grant order host, blit, host, blit…; no two consecutive grants to the same requester.
- Blit write: blit_wr=1, addr=16'h8000, data=16'h5A5A -> vram_wr_o=1 with those values, blit_ack_o=1 for one cycle, no blit_rd_valid_o.
- Reset mid-read: host read acked, reset_n_i low at N+1 -> host_rd_valid_o stays 0, host_data_o=0, vram_sel_o=0 during reset.
- With VRAM_ARB_PERF_EN: host_req held through 3 video cycles before ack -> host_wait_cnt_o=3; perf_clr_i=1 for one cycle -> 0.
